// File: rtl/mmc1_serial_writer_pkg.sv
// Shared types and constants for the MMC1 serial register writer.
package mmc1_pkg;

    localparam logic [1:0] REG_CONTROL = 2'b00;
    localparam logic [1:0] REG_CHR0    = 2'b01;
    localparam logic [1:0] REG_CHR1    = 2'b10;
    localparam logic [1:0] REG_PRG     = 2'b11;

    localparam int unsigned DATA_WRITES  = 5;
    localparam int unsigned RESET_WRITES = 1;
    localparam int unsigned BIT_W        = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WRITE,
        GAP
    } state_e;

    // Registered view of the synthetic CPU bus, minus M2.
    typedef struct packed {
        logic       romsel_n;
        logic       rw_n;
        logic [1:0] a;
        logic       d7;
        logic       d0;
    } cpu_bus_t;

    function automatic cpu_bus_t bus_idle(input logic [1:0] a);
        cpu_bus_t b;
        b.romsel_n = 1'b1;
        b.rw_n     = 1'b1;
        b.a        = a;
        b.d7       = 1'b0;
        b.d0       = 1'b0;
        return b;
    endfunction

    function automatic cpu_bus_t bus_write(input logic [1:0] a, input logic d7, input logic d0);
        cpu_bus_t b;
        b.romsel_n = 1'b0;
        b.rw_n     = 1'b0;
        b.a        = a;
        b.d7       = d7;
        b.d0       = d7 ? 1'b0 : d0;
        return b;
    endfunction

endpackage

// File: rtl/mmc1_serial_writer_if.sv
// Request handshake plus synthetic NES CPU bus driven by the serial writer.
interface mmc1_serial_writer_if;

    logic       REQ;
    logic       REQ_RESET;
    logic [1:0] REQ_REG;
    logic [4:0] REQ_DATA;
    logic       READY;
    logic       DONE;

    logic       CPU_M2;
    logic       CPU_A13;
    logic       CPU_A14;
    logic       nCPU_ROMSEL;
    logic       nCPU_RW;
    logic       CPU_D0;
    logic       CPU_D7;

    modport master (
        input  REQ, REQ_RESET, REQ_REG, REQ_DATA,
        output READY, DONE,
        output CPU_M2, CPU_A13, CPU_A14, nCPU_ROMSEL, nCPU_RW, CPU_D0, CPU_D7
    );

    modport slave (
        output REQ, REQ_RESET, REQ_REG, REQ_DATA,
        input  READY, DONE,
        input  CPU_M2, CPU_A13, CPU_A14, nCPU_ROMSEL, nCPU_RW, CPU_D0, CPU_D7
    );

endinterface

// File: rtl/mmc1_serial_writer_m2_phase_gen.sv
// Free-running M2 generator; bstb_c marks the CLK edge one cycle after M2 falls.
module m2_phase_gen #(
    parameter int unsigned HALF = 6
) (
    input  logic CLK,
    input  logic nRST,
    output logic m2_q,
    output logic bstb_c
);

    localparam int unsigned PERIOD = 2 * HALF;
    localparam int unsigned PH_W   = $clog2(PERIOD);

    logic [PH_W-1:0] ph_q, ph_d;
    logic            m2_d;

    always_comb begin
        ph_d = ph_q + PH_W'(1);
        if (ph_q == PH_W'(PERIOD - 1)) begin
            ph_d = '0;
        end
        m2_d = (ph_d >= PH_W'(HALF));
    end

    // Bus updates land on the edge that moves ph to 1.
    assign bstb_c = (ph_d == PH_W'(1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ph_q <= '0;
            m2_q <= 1'b0;
        end else begin
            ph_q <= ph_d;
            m2_q <= m2_d;
        end
    end

endmodule

// File: rtl/mmc1_serial_writer.sv
// Replays one MMC1 register write (or shift reset) as serial CPU bus writes.
module mmc1_serial_writer #(
    parameter int unsigned HALF       = 6,
    parameter int unsigned GAP        = 1,
    parameter bit          AUTO_RESET = 1'b0
) (
    input  logic                        CLK,
    input  logic                        nRST,
    mmc1_serial_writer_if.master        wr_if
);

    import mmc1_pkg::state_e;
    import mmc1_pkg::cpu_bus_t;
    import mmc1_pkg::bus_idle;
    import mmc1_pkg::bus_write;
    import mmc1_pkg::BIT_W;
    import mmc1_pkg::DATA_WRITES;

    localparam int unsigned GAP_W = $clog2(GAP + 1);

    state_e           state_q, state_d;
    logic             req_rst_q, req_rst_d;
    logic [1:0]       reg_q, reg_d;
    logic [4:0]       data_q, data_d;
    logic             pre_q, pre_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    cpu_bus_t         cpu_q, cpu_d;

    logic             m2_q;
    logic             bstb_c;
    logic             last_c;

    m2_phase_gen #(.HALF(HALF)) u_m2 (
        .CLK    (CLK),
        .nRST   (nRST),
        .m2_q   (m2_q),
        .bstb_c (bstb_c)
    );

    // A pending pre-reset write is never the last one.
    assign last_c = req_rst_q || (!pre_q && (bit_q == BIT_W'(DATA_WRITES - 1)));

    always_comb begin
        state_d   = state_q;
        req_rst_d = req_rst_q;
        reg_d     = reg_q;
        data_d    = data_q;
        pre_d     = pre_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        cpu_d     = cpu_q;

        unique case (state_q)
            mmc1_pkg::IDLE: begin
                if (wr_if.REQ) begin
                    req_rst_d = wr_if.REQ_RESET;
                    reg_d     = wr_if.REQ_REG;
                    data_d    = wr_if.REQ_DATA;
                    bit_d     = '0;
                    pre_d     = AUTO_RESET && !wr_if.REQ_RESET;
                    state_d   = mmc1_pkg::ARM;
                end
            end
            mmc1_pkg::ARM: begin
                if (bstb_c) begin
                    cpu_d   = bus_write(reg_q, pre_q || req_rst_q, data_q[0]);
                    state_d = mmc1_pkg::WRITE;
                end
            end
            mmc1_pkg::WRITE: begin
                if (bstb_c) begin
                    cpu_d = bus_idle(reg_q);
                    if (last_c) begin
                        done_d  = 1'b1;
                        state_d = mmc1_pkg::IDLE;
                    end else begin
                        gap_d   = GAP_W'(GAP);
                        state_d = mmc1_pkg::GAP;
                    end
                end
            end
            mmc1_pkg::GAP: begin
                if (bstb_c) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_d == '0) begin
                        if (pre_q) begin
                            pre_d = 1'b0;
                            cpu_d = bus_write(reg_q, 1'b0, data_q[0]);
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                            cpu_d = bus_write(reg_q, 1'b0, data_q[bit_d]);
                        end
                        state_d = mmc1_pkg::WRITE;
                    end
                end
            end
            default: begin
                state_d = mmc1_pkg::IDLE;
            end
        endcase

        ready_d = (state_d == mmc1_pkg::IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= mmc1_pkg::IDLE;
            req_rst_q <= 1'b0;
            reg_q     <= '0;
            data_q    <= '0;
            pre_q     <= 1'b0;
            bit_q     <= '0;
            gap_q     <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            cpu_q     <= bus_idle(2'b00);
        end else begin
            state_q   <= state_d;
            req_rst_q <= req_rst_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            pre_q     <= pre_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            cpu_q     <= cpu_d;
        end
    end

    assign wr_if.READY       = ready_q;
    assign wr_if.DONE        = done_q;
    assign wr_if.CPU_M2      = m2_q;
    assign wr_if.CPU_A14     = cpu_q.a[1];
    assign wr_if.CPU_A13     = cpu_q.a[0];
    assign wr_if.nCPU_ROMSEL = cpu_q.romsel_n;
    assign wr_if.nCPU_RW     = cpu_q.rw_n;
    assign wr_if.CPU_D0      = cpu_q.d0;
    assign wr_if.CPU_D7      = cpu_q.d7;

endmodule
